mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 18 +
 rtl/mem_arbiter_if.sv | 47 ++++
 rtl/mem_arbiter.sv | 120 ++++++++++++
 tb/tb_mem_arbiter.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-port memory arbiter: FSM state encoding and port indices.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2,
    ACK  = 2'd3
  } state_e;

  localparam logic PORT_CORE = 1'b0;
  localparam logic PORT_LOAD = 1'b1;

  function automatic state_e gnt_state(input logic port);
    return (port == PORT_LOAD) ? GNT1 : GNT0;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the core/loader requesters, the arbiter and the unified memory.
interface mem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);

  logic          req0;
  logic          we0;
  logic [AW-1:0] adr0;
  logic [DW-1:0] wd0;
  logic          ack0;
  logic [DW-1:0] rd0;

  logic          req1;
  logic          we1;
  logic [AW-1:0] adr1;
  logic [DW-1:0] wd1;
  logic          ack1;
  logic [DW-1:0] rd1;

  logic          mem_we;
  logic [AW-1:0] mem_adr;
  logic [DW-1:0] mem_wd;
  logic [DW-1:0] mem_rd;
  logic          busy;

  modport slave (
    input  req0, we0, adr0, wd0,
    output ack0, rd0,
    input  req1, we1, adr1, wd1,
    output ack1, rd1,
    output mem_we, mem_adr, mem_wd,
    input  mem_rd,
    output busy
  );

  modport master (
    output req0, we0, adr0, wd0,
    input  ack0, rd0,
    output req1, we1, adr1, wd1,
    input  ack1, rd1,
    input  mem_we, mem_adr, mem_wd,
    output mem_rd,
    input  busy
  );

endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates core (port 0) and loader (port 1) onto one single-ported memory, 3 cycles per access.
// Build option MEM_ARB_RR_EN: round-robin tie-break; otherwise the core port always wins ties.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic         clk,
  input  logic         reset,
  mem_arbiter_if.slave bus
);

  state_e        state_q, state_d;
  logic          ack_port_q, ack_port_d;
  logic [AW-1:0] adr_s;
  logic [DW-1:0] wd_s;
  logic          we_s;
  logic          ack0_s, ack1_s;
`ifdef MEM_ARB_RR_EN
  logic          ptr_q, ptr_d;
`endif

  // Next state; arbitration only happens from IDLE, so an ACK never re-grants.
  always_comb begin
    state_d    = state_q;
    ack_port_d = ack_port_q;
`ifdef MEM_ARB_RR_EN
    ptr_d      = ptr_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.req0 && bus.req1) begin
`ifdef MEM_ARB_RR_EN
          state_d = gnt_state(~ptr_q);
          ptr_d   = ~ptr_q;
`else
          state_d = gnt_state(PORT_CORE);
`endif
        end else if (bus.req0) begin
          state_d = gnt_state(PORT_CORE);
`ifdef MEM_ARB_RR_EN
          ptr_d   = PORT_CORE;
`endif
        end else if (bus.req1) begin
          state_d = gnt_state(PORT_LOAD);
`ifdef MEM_ARB_RR_EN
          ptr_d   = PORT_LOAD;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      GNT0: begin
        state_d    = ACK;
        ack_port_d = PORT_CORE;
      end
      GNT1: begin
        state_d    = ACK;
        ack_port_d = PORT_LOAD;
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous reset; pointer resets to the loader so the core wins first.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      ack_port_q <= PORT_CORE;
`ifdef MEM_ARB_RR_EN
      ptr_q      <= PORT_LOAD;
`endif
    end else begin
      state_q    <= state_d;
      ack_port_q <= ack_port_d;
`ifdef MEM_ARB_RR_EN
      ptr_q      <= ptr_d;
`endif
    end
  end

  // Memory command mux: requesters hold their command stable, so it is passed straight through.
  always_comb begin
    adr_s = bus.adr0;
    wd_s  = bus.wd0;
    we_s  = 1'b0;
    case (state_q)
      GNT0: begin
        adr_s = bus.adr0;
        wd_s  = bus.wd0;
        we_s  = bus.we0;
      end
      GNT1: begin
        adr_s = bus.adr1;
        wd_s  = bus.wd1;
        we_s  = bus.we1;
      end
      default: begin
        adr_s = bus.adr0;
        wd_s  = bus.wd0;
        we_s  = 1'b0;
      end
    endcase
  end

  assign ack0_s = (state_q == ACK) && (ack_port_q == PORT_CORE);
  assign ack1_s = (state_q == ACK) && (ack_port_q == PORT_LOAD);

  assign bus.mem_adr = adr_s;
  assign bus.mem_wd  = wd_s;
  assign bus.mem_we  = we_s;
  assign bus.ack0    = ack0_s;
  assign bus.ack1    = ack1_s;
  assign bus.rd0     = ack0_s ? bus.mem_rd : {DW{1'b0}};
  assign bus.rd1     = ack1_s ? bus.mem_rd : {DW{1'b0}};
  assign bus.busy    = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus a randomized run against a transaction-level model.
module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic reset;
  int   vectors = 0;
  int   errors  = 0;

  always #5 clk = ~clk;

  mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  mem_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Memory model: read data one cycle after the address; unwritten words return a fixed pattern.
  logic [DW-1:0] mem [256];
  bit            mem_vld [256];

  function automatic logic [31:0] mem_init(input logic [7:0] a);
    if (a == 8'h40) return 32'hDEADBEEF;
    return {a, ~a, a ^ 8'h5A, 8'hC3};
  endfunction

  function automatic logic [31:0] mem_val(input logic [7:0] a);
    return mem_vld[a] ? mem[a] : mem_init(a);
  endfunction

  always @(posedge clk) begin
    if (bus.mem_we) begin
      mem[bus.mem_adr[7:0]]     <= bus.mem_wd;
      mem_vld[bus.mem_adr[7:0]] <= 1'b1;
    end
    bus.mem_rd <= mem_val(bus.mem_adr[7:0]);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req0 = 1'b0; bus.we0 = 1'b0; bus.adr0 = 32'h0; bus.wd0 = 32'h0;
    bus.req1 = 1'b0; bus.we1 = 1'b0; bus.adr1 = 32'h0; bus.wd1 = 32'h0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    vectors++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
    vectors++; if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL rst_mem_we: got %b want 0", bus.mem_we); end
    vectors++; if (bus.ack0 !== 1'b0) begin errors++; $display("FAIL rst_ack0: got %b want 0", bus.ack0); end
    vectors++; if (bus.ack1 !== 1'b0) begin errors++; $display("FAIL rst_ack1: got %b want 0", bus.ack1); end
    vectors++; if (bus.rd0 !== 32'h0) begin errors++; $display("FAIL rst_rd0: got %h want 0", bus.rd0); end
    reset = 1'b0;
  endtask

  task automatic test_read_core();
    do_reset();
    bus.req0 = 1'b1; bus.we0 = 1'b0; bus.adr0 = 32'h40;
    tick();
    vectors++; if (bus.mem_adr !== 32'h40) begin errors++; $display("FAIL rd_mem_adr: got %h want 40", bus.mem_adr); end
    vectors++; if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL rd_mem_we: got %b want 0", bus.mem_we); end
    vectors++; if (bus.ack0 !== 1'b0) begin errors++; $display("FAIL rd_ack0_early: got %b want 0", bus.ack0); end
    vectors++; if (bus.ack1 !== 1'b0) begin errors++; $display("FAIL rd_ack1_n1: got %b want 0", bus.ack1); end
    vectors++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL rd_busy: got %b want 1", bus.busy); end
    tick();
    vectors++; if (bus.ack0 !== 1'b1) begin errors++; $display("FAIL rd_ack0: got %b want 1", bus.ack0); end
    vectors++; if (bus.rd0 !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_rd0: got %h want deadbeef", bus.rd0); end
    vectors++; if (bus.ack1 !== 1'b0) begin errors++; $display("FAIL rd_ack1_n2: got %b want 0", bus.ack1); end
    vectors++; if (bus.rd1 !== 32'h0) begin errors++; $display("FAIL rd_rd1: got %h want 0", bus.rd1); end
    bus.req0 = 1'b0;
    tick();
    vectors++; if (bus.ack0 !== 1'b0) begin errors++; $display("FAIL rd_ack0_once: got %b want 0", bus.ack0); end
    vectors++; if (bus.ack1 !== 1'b0) begin errors++; $display("FAIL rd_ack1_n3: got %b want 0", bus.ack1); end
    vectors++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rd_idle: got %b want 0", bus.busy); end
  endtask

  task automatic test_write_load();
    do_reset();
    bus.req1 = 1'b1; bus.we1 = 1'b1; bus.adr1 = 32'h10; bus.wd1 = 32'h1234;
    tick();
    vectors++; if (bus.mem_we !== 1'b1) begin errors++; $display("FAIL wr_mem_we: got %b want 1", bus.mem_we); end
    vectors++; if (bus.mem_wd !== 32'h1234) begin errors++; $display("FAIL wr_mem_wd: got %h want 1234", bus.mem_wd); end
    vectors++; if (bus.mem_adr !== 32'h10) begin errors++; $display("FAIL wr_mem_adr: got %h want 10", bus.mem_adr); end
    vectors++; if (bus.ack1 !== 1'b0) begin errors++; $display("FAIL wr_ack1_early: got %b want 0", bus.ack1); end
    tick();
    vectors++; if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL wr_we_once: got %b want 0", bus.mem_we); end
    vectors++; if (bus.ack1 !== 1'b1) begin errors++; $display("FAIL wr_ack1: got %b want 1", bus.ack1); end
    vectors++; if (bus.ack0 !== 1'b0) begin errors++; $display("FAIL wr_ack0: got %b want 0", bus.ack0); end
    bus.req1 = 1'b0; bus.we1 = 1'b0;
    tick();
    vectors++; if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL wr_we_after: got %b want 0", bus.mem_we); end
    vectors++; if (mem_val(8'h10) !== 32'h1234) begin errors++; $display("FAIL wr_stored: got %h want 1234", mem_val(8'h10)); end
  endtask

  task automatic test_tie();
    int grants [$];
    int want [4];
`ifdef MEM_ARB_RR_EN
    want = '{0, 1, 0, 1};
`else
    want = '{0, 0, 0, 0};
`endif
    do_reset();
    bus.req0 = 1'b1; bus.adr0 = 32'h20;
    bus.req1 = 1'b1; bus.adr1 = 32'h30;
    for (int c = 0; c < 30 && grants.size() < 4; c++) begin
      tick();
      if (bus.ack0 === 1'b1 && bus.ack1 === 1'b1) begin
        vectors++; errors++;
        $display("FAIL tie_double_ack: got ack0=1 ack1=1 want one-hot");
      end
      if (bus.ack0 === 1'b1) grants.push_back(0);
      else if (bus.ack1 === 1'b1) grants.push_back(1);
    end
    vectors++;
    if (grants.size() != 4) begin
      errors++;
      $display("FAIL tie_timeout: got %0d grants want 4", grants.size());
    end
    for (int i = 0; i < grants.size() && i < 4; i++) begin
      vectors++;
      if (grants[i] != want[i]) begin
        errors++;
        $display("FAIL tie_grant%0d: got port %0d want port %0d", i, grants[i], want[i]);
      end
    end
    idle_inputs();
    tick();
    tick();
  endtask

  task automatic test_reset_in_gnt();
    do_reset();
    bus.req0 = 1'b1; bus.we0 = 1'b1; bus.adr0 = 32'h50; bus.wd0 = 32'hA5A5;
    tick();
    vectors++; if (bus.mem_we !== 1'b1) begin errors++; $display("FAIL rg_we_gnt: got %b want 1", bus.mem_we); end
    reset = 1'b1;
    tick();
    vectors++; if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL rg_we_supp: got %b want 0", bus.mem_we); end
    vectors++; if (bus.ack0 !== 1'b0) begin errors++; $display("FAIL rg_ack0: got %b want 0", bus.ack0); end
    vectors++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rg_idle: got %b want 0", bus.busy); end
    reset = 1'b0;
    idle_inputs();
    bus.req1 = 1'b1; bus.adr1 = 32'h60;
    tick();
    vectors++; if (bus.ack0 !== 1'b0) begin errors++; $display("FAIL rg_no_ack0: got %b want 0", bus.ack0); end
    vectors++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL rg_rearb: got %b want 1", bus.busy); end
    vectors++; if (bus.mem_adr !== 32'h60) begin errors++; $display("FAIL rg_adr: got %h want 60", bus.mem_adr); end
    tick();
    vectors++; if (bus.ack1 !== 1'b1) begin errors++; $display("FAIL rg_ack1: got %b want 1", bus.ack1); end
    idle_inputs();
    tick();
  endtask

  task automatic test_drop_req();
    logic [31:0] exp_rd;
    do_reset();
    exp_rd = mem_val(8'h44);
    bus.req0 = 1'b1; bus.we0 = 1'b0; bus.adr0 = 32'h44;
    tick();
    bus.req0 = 1'b0;
    tick();
    vectors++; if (bus.ack0 !== 1'b1) begin errors++; $display("FAIL drop_ack0: got %b want 1", bus.ack0); end
    vectors++; if (bus.rd0 !== exp_rd) begin errors++; $display("FAIL drop_rd0: got %h want %h", bus.rd0, exp_rd); end
    tick();
    vectors++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL drop_idle: got %b want 0", bus.busy); end
    vectors++; if (bus.ack0 !== 1'b0) begin errors++; $display("FAIL drop_ack0_once: got %b want 0", bus.ack0); end
  endtask

  task automatic test_idle();
    do_reset();
    for (int c = 0; c < 10; c++) begin
      tick();
      vectors++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL idle_busy[%0d]: got %b want 0", c, bus.busy); end
      vectors++; if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL idle_we[%0d]: got %b want 0", c, bus.mem_we); end
      vectors++; if (bus.ack0 !== 1'b0) begin errors++; $display("FAIL idle_ack0[%0d]: got %b want 0", c, bus.ack0); end
      vectors++; if (bus.ack1 !== 1'b0) begin errors++; $display("FAIL idle_ack1[%0d]: got %b want 0", c, bus.ack1); end
    end
  endtask

  // Transaction model: each access occupies memory the cycle after grant, acks the cycle after that.
  task automatic test_random();
    logic        pend [2];
    logic        we_m [2];
    logic [31:0] adr_m [2];
    logic [31:0] wd_m [2];
    logic [31:0] exp_rd, rd_c, rd_o;
    logic        ack_c, ack_o;
    int          phase, cur, last;
    do_reset();
    phase = 0; cur = 0; last = 1; exp_rd = 32'h0;
    for (int p = 0; p < 2; p++) begin
      pend[p] = 1'b0; we_m[p] = 1'b0; adr_m[p] = 32'h0; wd_m[p] = 32'h0;
    end
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int p = 0; p < 2; p++) begin
        if (!pend[p] && ($urandom_range(0, 2) == 0)) begin
          pend[p]  = 1'b1;
          we_m[p]  = 1'($urandom_range(0, 1));
          adr_m[p] = 32'($urandom_range(0, 255));
          wd_m[p]  = $urandom;
        end
      end
      bus.req0 = pend[0]; bus.we0 = we_m[0]; bus.adr0 = adr_m[0]; bus.wd0 = wd_m[0];
      bus.req1 = pend[1]; bus.we1 = we_m[1]; bus.adr1 = adr_m[1]; bus.wd1 = wd_m[1];
      if (phase == 0) begin
        if (pend[0] || pend[1]) begin
          if (pend[0] && pend[1]) begin
`ifdef MEM_ARB_RR_EN
            cur = 1 - last;
`else
            cur = 0;
`endif
          end else begin
            cur = pend[0] ? 0 : 1;
          end
          last  = cur;
          phase = 1;
        end
      end else if (phase == 1) begin
        phase = 2;
      end else begin
        phase = 0;
      end
      tick();
      ack_c = (cur == 0) ? bus.ack0 : bus.ack1;
      ack_o = (cur == 0) ? bus.ack1 : bus.ack0;
      rd_c  = (cur == 0) ? bus.rd0  : bus.rd1;
      rd_o  = (cur == 0) ? bus.rd1  : bus.rd0;
      if (phase == 0) begin
        vectors++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rnd_idle_busy@%0d: got %b want 0", cyc, bus.busy); end
        vectors++; if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL rnd_idle_we@%0d: got %b want 0", cyc, bus.mem_we); end
        vectors++; if ({bus.ack0, bus.ack1} !== 2'b00) begin errors++; $display("FAIL rnd_idle_ack@%0d: got %b%b want 00", cyc, bus.ack0, bus.ack1); end
        vectors++; if ({bus.rd0, bus.rd1} !== 64'h0) begin errors++; $display("FAIL rnd_idle_rd@%0d: got %h/%h want 0", cyc, bus.rd0, bus.rd1); end
      end else if (phase == 1) begin
        exp_rd = mem_val(adr_m[cur][7:0]);
        vectors++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL rnd_gnt_busy@%0d: got %b want 1", cyc, bus.busy); end
        vectors++; if (bus.mem_adr !== adr_m[cur]) begin errors++; $display("FAIL rnd_gnt_adr@%0d: got %h want %h (port %0d)", cyc, bus.mem_adr, adr_m[cur], cur); end
        vectors++; if (bus.mem_we !== we_m[cur]) begin errors++; $display("FAIL rnd_gnt_we@%0d: got %b want %b", cyc, bus.mem_we, we_m[cur]); end
        if (we_m[cur]) begin
          vectors++; if (bus.mem_wd !== wd_m[cur]) begin errors++; $display("FAIL rnd_gnt_wd@%0d: got %h want %h", cyc, bus.mem_wd, wd_m[cur]); end
        end
        vectors++; if ({bus.ack0, bus.ack1} !== 2'b00) begin errors++; $display("FAIL rnd_gnt_ack@%0d: got %b%b want 00", cyc, bus.ack0, bus.ack1); end
      end else begin
        vectors++; if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL rnd_ack_we@%0d: got %b want 0", cyc, bus.mem_we); end
        vectors++; if (ack_c !== 1'b1) begin errors++; $display("FAIL rnd_ack_own@%0d: got %b want 1 (port %0d)", cyc, ack_c, cur); end
        vectors++; if (ack_o !== 1'b0) begin errors++; $display("FAIL rnd_ack_other@%0d: got %b want 0", cyc, ack_o); end
        vectors++; if (rd_o !== 32'h0) begin errors++; $display("FAIL rnd_rd_other@%0d: got %h want 0", cyc, rd_o); end
        if (!we_m[cur]) begin
          vectors++; if (rd_c !== exp_rd) begin errors++; $display("FAIL rnd_rd@%0d: got %h want %h", cyc, rd_c, exp_rd); end
        end
        pend[cur] = 1'b0;
      end
    end
    idle_inputs();
    tick();
    tick();
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_read_core();
    test_write_load();
    test_tie();
    test_reset_in_gnt();
    test_drop_req();
    test_idle();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
